// File: rtl/shared_mem_pkg.sv
// Shared definitions for the shared-memory arbiter: default geometry and
// the request / in-flight tag record types.
package shared_mem_pkg;

    localparam int NCORE_DEF   = 4;
    localparam int ADDR_W_DEF  = 15;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 2;

    typedef logic [$clog2(NCORE_DEF)-1:0] core_id_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] din;
    } mem_req_t;

    typedef struct packed {
        logic     valid;
        core_id_t id;
    } tag_t;

endpackage

// File: rtl/shared_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward (wrapping) and
// grants the first active request, returning one-hot grant, index and next pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any_gnt,
    output logic [IW-1:0] ptr_nxt
);

    logic [IW-1:0] idx;

    // priority scan starting at the pointer
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_id  = {IW{1'b0}};
        any_gnt = 1'b0;
        ptr_nxt = ptr;
        idx     = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                any_gnt  = 1'b1;
                ptr_nxt  = IW'((int'(idx) + 1) % N);
            end else begin
                any_gnt = any_gnt;
            end
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin sharing of one BRAM port among NCORE cores, with a tag pipeline
// that steers each read's returning data to the core that issued it.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int NCORE   = NCORE_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCORE-1:0]          req,
    input  logic [NCORE-1:0]          we,
    input  logic [NCORE*ADDR_W-1:0]   addr,
    input  logic [NCORE*DATA_W-1:0]   din,
    output logic [NCORE-1:0]          mem_wait,
    output logic [NCORE-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] id;
    } tag_ent_t;

    logic [NCORE-1:0]  req_live;
    logic [NCORE-1:0]  gnt;
    logic [IW-1:0]     gnt_id;
    logic [IW-1:0]     ptr_nxt;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;

    logic [IW-1:0]     ptr_q, ptr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NCORE-1:0]  rvalid_q, rvalid_d;
    tag_ent_t          tag_q [0:MEM_LAT];
    tag_ent_t          tag_d [0:MEM_LAT];

    assign req_live = rst ? {NCORE{1'b0}} : req;

    rr_arbiter #(.N(NCORE), .IW(IW)) u_rr_arbiter (
        .req     (req_live),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_gnt (any_gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign mem_wait = req & ~gnt;

    // AND-OR mux on the one-hot grant so idle cores' inputs never leak through
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = {ADDR_W{1'b0}};
        sel_din  = {DATA_W{1'b0}};
        for (int i = 0; i < NCORE; i++) begin
            sel_we   = sel_we   | (we[i] & gnt[i]);
            sel_addr = sel_addr | (addr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt[i]}});
            sel_din  = sel_din  | (din[i*DATA_W +: DATA_W]  & {DATA_W{gnt[i]}});
        end
    end

    // next state: issue register, tag shift, read return
    always_comb begin
        ptr_d      = ptr_q;
        mem_en_d   = any_gnt;
        mem_we_d   = sel_we;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (any_gnt) begin
            ptr_d      = ptr_nxt;
            mem_addr_d = sel_addr;
            mem_din_d  = sel_din;
        end else begin
            ptr_d      = ptr_q;
        end

        tag_d[0].valid = any_gnt & ~sel_we;
        tag_d[0].id    = gnt_id;
        for (int k = 1; k <= MEM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        // last tag stage lines up with mem_dout becoming valid
        rvalid_d = {NCORE{1'b0}};
        rdata_d  = rdata_q;
        if (tag_q[MEM_LAT].valid) begin
            rvalid_d[tag_q[MEM_LAT].id] = 1'b1;
            rdata_d                     = mem_dout;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= {IW{1'b0}};
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_din_q  <= {DATA_W{1'b0}};
            rdata_q    <= {DATA_W{1'b0}};
            rvalid_q   <= {NCORE{1'b0}};
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_q[k] <= '{valid: 1'b0, id: {IW{1'b0}}};
            end
        end else begin
            ptr_q      <= ptr_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed vector table, corner
// sequences and a random soak against a grant-order reference memory model.
module tb_shared_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   din;
    logic [N-1:0]      mem_wait, rvalid;
    logic [DW-1:0]     rdata, mem_din, mem_dout;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;

    always #5 clk = ~clk;

    shared_mem_arbiter #(.NCORE(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
        .mem_wait(mem_wait), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 15'h010) return 32'hDEAD_BEEF;
        return 32'hA500_0000 | {17'd0, a};
    endfunction

    // BRAM model: unwritten words read back as init_word
    logic [DW-1:0] bram_d  [32768];
    bit            bram_wr [32768];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            bram_d[mem_addr]  <= mem_din;
            bram_wr[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            rd_pipe[0] <= bram_wr[mem_addr] ? bram_d[mem_addr] : init_word(mem_addr);
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_dout = rd_pipe[LAT-1];

    int errs = 0;
    int checks = 0;

    // reference model state
    int            cyc = 0;
    int            m_ptr = 0;
    logic          m_en = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0, m_rdata = '0;
    logic [DW-1:0] ref_mem [int];
    logic [1:0]    ret_id [int];
    logic [DW-1:0] ret_d  [int];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // check this cycle against the model, advance the model, then advance the clock
    task automatic step();
        logic [N-1:0] gm, ev;
        logic [1:0]   idx, g;
        logic         found;
        #1;
        chk("mem_en",   64'(mem_en),   64'(m_en));
        chk("mem_we",   64'(mem_we),   64'(m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_din",  64'(mem_din),  64'(m_din));
        ev = '0;
        if (ret_id.exists(cyc)) begin
            ev[ret_id[cyc]] = 1'b1;
            m_rdata = ret_d[cyc];
        end
        chk("rvalid", 64'(rvalid), 64'(ev));
        chk("rdata",  64'(rdata),  64'(m_rdata));
        chk("rvalid_onehot", 64'($countones(rvalid) <= 1), 64'd1);
        found = 1'b0; g = 2'd0; gm = '0;
        for (int k = 0; k < N; k++) begin
            idx = 2'((m_ptr + k) % N);
            if (!rst && !found && req[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
        if (found) gm[g] = 1'b1;
        chk("mem_wait", 64'(mem_wait), 64'(req & ~gm));
        chk("single_grant", 64'($countones(req & ~mem_wait) <= 1), 64'd1);
        if (rst) begin
            m_ptr = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0; m_rdata = '0;
            for (int k = cyc + 1; k <= cyc + LAT + 2; k++) begin
                ret_id.delete(k);
                ret_d.delete(k);
            end
        end else if (found) begin
            m_ptr  = (int'(g) + 1) % N;
            m_en   = 1'b1;
            m_we   = we[g];
            m_addr = addr[int'(g)*AW +: AW];
            m_din  = din[int'(g)*DW +: DW];
            if (m_we) begin
                ref_mem[int'(m_addr)] = m_din;
            end else begin
                ret_id[cyc + LAT + 2] = g;
                ret_d[cyc + LAT + 2]  = ref_rd(m_addr);
            end
        end else begin
            m_en = 1'b0;
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] exp_w, input string nm);
        rst = r;
        req = rq;
        #1;
        chk(nm, 64'(mem_wait), 64'(exp_w));
        step();
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  exp_wait;
        logic        exp_en;
        logic [3:0]  exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tv [13];

    initial begin
        for (int i = 0; i < 3; i++) tv[i] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 32'h0};
        tv[3]  = '{1'b0, 4'b1111, 4'b1110, 1'b0, 4'b0000, 32'h0};
        tv[4]  = '{1'b0, 4'b1111, 4'b1101, 1'b1, 4'b0000, 32'h0};
        tv[5]  = '{1'b0, 4'b1111, 4'b1011, 1'b1, 4'b0000, 32'h0};
        tv[6]  = '{1'b0, 4'b1111, 4'b0111, 1'b1, 4'b0000, 32'h0};
        tv[7]  = '{1'b0, 4'b1111, 4'b1110, 1'b1, 4'b0001, 32'hA500_0100};
        tv[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 32'hA500_0101};
        tv[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0100, 32'hA500_0102};
        tv[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1000, 32'hA500_0103};
        tv[11] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0001, 32'hA500_0100};
        tv[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'hA500_0100};

        rst = 1'b1; req = 4'b1111; we = 4'b0000; din = '0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = 15'(32'h100 + i);
        @(posedge clk);
        #1;

        // reset and full contention, all reads
        for (int i = 0; i < 13; i++) begin
            rst = tv[i].rst;
            req = tv[i].req;
            #1;
            chk("tbl_wait",   64'(mem_wait), 64'(tv[i].exp_wait));
            chk("tbl_en",     64'(mem_en),   64'(tv[i].exp_en));
            chk("tbl_rvalid", 64'(rvalid),   64'(tv[i].exp_rv));
            chk("tbl_rdata",  64'(rdata),    64'(tv[i].exp_rd));
            step();
        end

        // rotation: bring ptr to 2, then low cores win by wrapping
        apply(1'b0, 4'b0010, 4'b0000, "rot_setup");
        apply(1'b0, 4'b0011, 4'b0010, "rot_core0");
        apply(1'b0, 4'b0010, 4'b0000, "rot_core1");
        apply(1'b0, 4'b1111, 4'b1011, "rot_ptr2");
        req = 4'b0000;
        for (int i = 0; i < 6; i++) step();

        // single read of a preloaded word
        addr[2*AW +: AW] = 15'h010;
        apply(1'b0, 4'b0100, 4'b0000, "rd_grant");
        req = 4'b0000;
        chk("rd_issue_en",   64'(mem_en),   64'd1);
        chk("rd_issue_addr", 64'(mem_addr), 64'h010);
        step(); step(); step();
        chk("rd_rvalid", 64'(rvalid), 64'b0100);
        chk("rd_rdata",  64'(rdata),  64'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step();

        // write followed immediately by a read of the same word
        we = 4'b0010;
        addr[1*AW +: AW] = 15'h020;
        din[1*DW +: DW]  = 32'h1234_5678;
        apply(1'b0, 4'b0010, 4'b0000, "wr_grant");
        we = 4'b0000;
        addr[3*AW +: AW] = 15'h020;
        apply(1'b0, 4'b1000, 4'b0000, "raw_grant");
        req = 4'b0000;
        step(); step();
        chk("wr_no_rvalid", 64'(rvalid), 64'd0);
        step();
        chk("raw_rvalid", 64'(rvalid), 64'b1000);
        chk("raw_rdata",  64'(rdata),  64'h1234_5678);
        for (int i = 0; i < 3; i++) step();

        // reset with two reads in flight
        addr[0*AW +: AW] = 15'h005;
        addr[1*AW +: AW] = 15'h006;
        apply(1'b0, 4'b0001, 4'b0000, "fl_rd0");
        apply(1'b0, 4'b0010, 4'b0000, "fl_rd1");
        apply(1'b1, 4'b0000, 4'b0000, "fl_rst");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("fl_no_rvalid", 64'(rvalid), 64'd0);
            step();
        end
        addr[2*AW +: AW] = 15'h010;
        apply(1'b0, 4'b0100, 4'b0000, "fl_after");
        req = 4'b0000;
        step(); step(); step();
        chk("fl_after_rvalid", 64'(rvalid), 64'b0100);
        chk("fl_after_rdata",  64'(rdata),  64'hDEAD_BEEF);

        // random soak against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            req = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    we[i] = 1'($urandom);
                    addr[i*AW +: AW] = 15'($urandom_range(0, 15));
                    din[i*DW +: DW]  = $urandom;
                end else begin
                    we[i] = 1'bx;
                    addr[i*AW +: AW] = 'x;
                    din[i*DW +: DW]  = 'x;
                end
            end
            step();
        end
        rst = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < LAT + 4; i++) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
